// File: rtl/base_sys_debounce_pkg.sv
// Shared types and helpers for the pushbutton debounce block.
package base_sys_debounce_pkg;

    // Raw input passes through this many flops before the FSM sees it.
    localparam int SYNC_STAGES = 2;

    // Per-channel debounce state.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    // Counter width for a given stability window, never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/base_sys_debounce_chan.sv
// One debounce channel: synchroniser, stability FSM/counter and edge strobes.
// Input is already polarity-corrected (1 = pressed).
module base_sys_debounce_chan
    import base_sys_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_clean,
    output logic btn_press,
    output logic btn_release
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    deb_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   press_q, press_d;
    logic                   rel_q, rel_d;
    logic                   differ;
    logic                   done;

    // Synchronised level disagrees with the accepted level.
    assign differ = sync_q[SYNC_STAGES-1] ^ clean_q;
    // Current cycle is the last one needed to accept the new level.
    assign done   = (cnt_q == CNT_LAST);

    // State register plus synchroniser, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Next state: leave STABLE on disagreement, return on reject or accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STABLE:  if (differ) state_d = ST_PENDING;
            ST_PENDING: if (!differ || done) state_d = ST_STABLE;
            default:    state_d = ST_STABLE;
        endcase
    end

    // Datapath: count disagreeing cycles; on the final one flip the level and strobe.
    // The first disagreeing cycle loads 1, so acceptance lands on the N-th one.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (state_q == ST_PENDING && differ && done) begin
            clean_d = ~clean_q;
            press_d = ~clean_q;
            rel_d   = clean_q;
        end else if (differ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign btn_clean   = clean_q;
    assign btn_press   = press_q;
    assign btn_release = rel_q;

endmodule

// File: rtl/base_sys_button_debounce.sv
// Multi-channel button conditioner feeding the system PIO in_port.
// Fixes polarity once, then runs an independent debounce channel per input.
module base_sys_button_debounce
    import base_sys_debounce_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    logic [WIDTH-1:0] pol_in;

    // Normalise to 1 = pressed before anything else touches the inputs.
    assign pol_in = ACTIVE_LOW ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        base_sys_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .btn_in      (pol_in[i]),
            .btn_clean   (btn_clean[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_base_sys_button_debounce.sv
// Bench for base_sys_button_debounce with DEBOUNCE_CYCLES=8, WIDTH=4, active-low pins.
module tb_base_sys_button_debounce;

    localparam int N = 8;
    localparam int W = 4;
    localparam int LAT = N + 2;

    typedef struct {
        int           cyc;
        logic [W-1:0] press;
        logic [W-1:0] rel;
        logic [W-1:0] clean;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] btn_raw = '1;
    logic [W-1:0] btn_clean, btn_press, btn_release;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Small PIO edge-capture model downstream of btn_clean.
    logic [W-1:0] pio_d1 = '0, pio_d2 = '0, edge_cap = '0;
    logic [W-1:0] irq_mask = '1;
    logic         cap_clr = 1'b0;
    logic         irq;
    int           cap_cnt1 = 0;

    base_sys_button_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_clean   (btn_clean),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        pio_d1   <= btn_clean;
        pio_d2   <= pio_d1;
        edge_cap <= cap_clr ? '0 : (edge_cap | (pio_d1 & ~pio_d2));
        cap_cnt1 <= cap_cnt1 + ((pio_d1[1] & ~pio_d2[1]) ? 1 : 0);
    end
    assign irq = |(edge_cap & irq_mask);

    // Every strobe must match the next scheduled event, in cycle and content.
    always @(negedge clk) begin
        if ((btn_press | btn_release) != '0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b", cyc, btn_press, btn_release);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || btn_press !== mon_e.press ||
                    btn_release !== mon_e.rel || btn_clean !== mon_e.clean) begin
                    miscompares++;
                    $display("FAIL strobe_event got cyc=%0d press=%b rel=%b clean=%b want cyc=%0d press=%b rel=%b clean=%b",
                             cyc, btn_press, btn_release, btn_clean,
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.clean);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick(2);
        vectors++;
        if (btn_clean !== '0 || btn_press !== '0 || btn_release !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs clean=%b press=%b rel=%b want all 0", btn_clean, btn_press, btn_release);
        end
        reset = 1'b0;
        tick(LAT + 2);
        vectors++;
        if (btn_clean !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset clean=%b want 0000", btn_clean);
        end
    endtask

    task automatic test_clean_press;
        int e;
        e = cyc;
        btn_raw[0] = 1'b0;
        sb.push_back('{e + LAT, 4'b0001, 4'b0000, 4'b0001});
        tick(LAT - 1);
        vectors++;
        if (btn_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL press_early clean=%b want 0000", btn_clean);
        end
        tick(1);
        vectors++;
        if (btn_clean !== 4'b0001 || btn_press !== 4'b0001) begin
            miscompares++;
            $display("FAIL press_edge clean=%b press=%b want 0001/0001", btn_clean, btn_press);
        end
        tick(1);
        vectors++;
        if (btn_press !== 4'b0000) begin
            miscompares++;
            $display("FAIL press_one_cycle press=%b want 0000", btn_press);
        end
        tick(9);
        vectors++;
        if (btn_clean !== 4'b0001) begin
            miscompares++;
            $display("FAIL press_hold clean=%b want 0001", btn_clean);
        end
        e = cyc;
        btn_raw[0] = 1'b1;
        sb.push_back('{e + LAT, 4'b0000, 4'b0001, 4'b0000});
        tick(LAT);
        vectors++;
        if (btn_clean !== 4'b0000 || btn_release !== 4'b0001) begin
            miscompares++;
            $display("FAIL release_edge clean=%b rel=%b want 0000/0001", btn_clean, btn_release);
        end
        tick(2);
    endtask

    task automatic test_bounce;
        int e;
        int base;
        cap_clr = 1'b1;
        tick(1);
        cap_clr = 1'b0;
        base = cap_cnt1;
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
            tick(3);
        end
        vectors++;
        if (btn_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL bounce_toggling clean=%b want 0000", btn_clean);
        end
        e = cyc;
        btn_raw[1] = 1'b0;
        sb.push_back('{e + LAT, 4'b0010, 4'b0000, 4'b0010});
        tick(LAT - 1);
        vectors++;
        if (btn_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL bounce_early clean=%b want 0000", btn_clean);
        end
        tick(1);
        vectors++;
        if (btn_clean !== 4'b0010) begin
            miscompares++;
            $display("FAIL bounce_settle clean=%b want 0010", btn_clean);
        end
        tick(4);
        vectors++;
        if (edge_cap !== 4'b0010 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL pio_capture edge_cap=%b irq=%b want 0010/1", edge_cap, irq);
        end
        e = cyc;
        btn_raw[1] = 1'b1;
        sb.push_back('{e + LAT, 4'b0000, 4'b0010, 4'b0000});
        tick(LAT + 2);
        vectors++;
        if (cap_cnt1 - base !== 1) begin
            miscompares++;
            $display("FAIL pio_capture_count got %0d want 1", cap_cnt1 - base);
        end
    endtask

    task automatic test_boundary;
        int e;
        btn_raw[3] = 1'b0;
        tick(N - 1);
        btn_raw[3] = 1'b1;
        tick(N + 5);
        vectors++;
        if (btn_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL glitch_7 clean=%b want 0000", btn_clean);
        end
        e = cyc;
        btn_raw[3] = 1'b0;
        sb.push_back('{e + LAT, 4'b1000, 4'b0000, 4'b1000});
        tick(N);
        btn_raw[3] = 1'b1;
        sb.push_back('{e + N + LAT, 4'b0000, 4'b1000, 4'b0000});
        tick(2);
        vectors++;
        if (btn_clean !== 4'b1000 || btn_press !== 4'b1000) begin
            miscompares++;
            $display("FAIL pulse_8_accept clean=%b press=%b want 1000/1000", btn_clean, btn_press);
        end
        tick(N);
        vectors++;
        if (btn_clean !== 4'b0000 || btn_release !== 4'b1000) begin
            miscompares++;
            $display("FAIL pulse_8_release clean=%b rel=%b want 0000/1000", btn_clean, btn_release);
        end
        tick(2);
    endtask

    task automatic test_simultaneous;
        int e;
        e = cyc;
        btn_raw = '0;
        sb.push_back('{e + LAT, 4'b1111, 4'b0000, 4'b1111});
        tick(LAT);
        vectors++;
        if (btn_clean !== 4'b1111 || btn_press !== 4'b1111 || btn_release !== 4'b0000) begin
            miscompares++;
            $display("FAIL simul_press clean=%b press=%b rel=%b want 1111/1111/0000", btn_clean, btn_press, btn_release);
        end
        tick(5);
        e = cyc;
        btn_raw = '1;
        sb.push_back('{e + LAT, 4'b0000, 4'b1111, 4'b0000});
        tick(LAT + 2);
        vectors++;
        if (btn_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL simul_release clean=%b want 0000", btn_clean);
        end
    endtask

    task automatic test_reset_mid;
        int e;
        e = cyc;
        btn_raw[0] = 1'b0;
        sb.push_back('{e + LAT, 4'b0001, 4'b0000, 4'b0001});
        tick(LAT + 2);
        btn_raw[2] = 1'b0;
        tick(7);
        reset = 1'b1;
        #1;
        vectors++;
        if (btn_clean !== 4'b0000 || btn_press !== 4'b0000 || btn_release !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid clean=%b press=%b rel=%b want all 0", btn_clean, btn_press, btn_release);
        end
        tick(3);
        reset = 1'b0;
        e = cyc;
        sb.push_back('{e + LAT, 4'b0101, 4'b0000, 4'b0101});
        tick(LAT - 1);
        vectors++;
        if (btn_press !== 4'b0000 || btn_clean !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_rearm_early press=%b clean=%b want 0000/0000", btn_press, btn_clean);
        end
        tick(1);
        vectors++;
        if (btn_press !== 4'b0101 || btn_clean !== 4'b0101) begin
            miscompares++;
            $display("FAIL reset_rearm press=%b clean=%b want 0101/0101", btn_press, btn_clean);
        end
        tick(3);
        e = cyc;
        btn_raw = '1;
        sb.push_back('{e + LAT, 4'b0000, 4'b0101, 4'b0000});
        tick(LAT + 2);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_boundary();
        test_simultaneous();
        test_reset_mid();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL missing_events got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
